// File: rtl/neuron_sad_pkg.sv
// Shared types and default sizing for the neuron SAD integrate-and-fire stage.
package neuron_sad_pkg;

  localparam int SAMPLE_W    = 8;
  localparam int ACC_W_DEF   = 12;
  localparam int WINDOW_DEF  = 16;
  localparam int REFRACT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FIRE,
    ST_REFRACT
  } state_t;

endpackage

// File: rtl/neuron_sat_add.sv
// Unsigned ACC_W-bit + sample-width saturating adder (combinational).
module neuron_sat_add
  import neuron_sad_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]    a,
  input  logic [SAMPLE_W-1:0] b,
  output logic [ACC_W-1:0]    sum
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    sum  = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
  end

endmodule

// File: rtl/neuron_sad_integrator.sv
// Windowed saturating integrate-and-fire stage with refractory hold-off.
module neuron_sad_integrator
  import neuron_sad_pkg::*;
#(
  parameter int WINDOW  = WINDOW_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int REFRACT = REFRACT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ACC_W-1:0]    threshold,
  output logic [ACC_W-1:0]    sad_out,
  output logic                sad_valid,
  output logic                spike
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int RW = $clog2(REFRACT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW - 1);

  state_t            state, state_nx;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [CW-1:0]     cnt;
  logic [RW-1:0]     rcnt;
  logic              accept;
  logic              last;

  neuron_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (in_data),
    .sum (acc_sum)
  );

  assign accept = in_valid && in_ready;
  assign last   = (state == ST_ACCUM) && accept && (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (accept) state_nx = ST_ACCUM;
      ST_ACCUM:   if (last) state_nx = ST_FIRE;
      // spike is registered, so it already reflects this window during FIRE
      ST_FIRE:    state_nx = spike ? ST_REFRACT : ST_IDLE;
      ST_REFRACT: if (rcnt == RW'(1)) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    if (!rst && (state == ST_IDLE || state == ST_ACCUM)) in_ready = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      rcnt      <= '0;
      sad_out   <= '0;
      sad_valid <= 1'b0;
      spike     <= 1'b0;
    end else begin
      sad_valid <= 1'b0;
      spike     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc <= ACC_W'(in_data);
            cnt <= CW'(1);
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc <= acc_sum;
            cnt <= cnt + CW'(1);
          end
          if (last) begin
            sad_out   <= acc_sum;
            sad_valid <= 1'b1;
            spike     <= (acc_sum >= threshold);
          end
        end
        ST_FIRE: begin
          acc <= '0;
          cnt <= '0;
          if (spike) rcnt <= RW'(REFRACT);
        end
        ST_REFRACT: rcnt <= rcnt - RW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_sad_integrator.sv
// Randomized self-checking bench for neuron_sad_integrator against a window-sum model.
module tb_neuron_sad_integrator;

  localparam int WIN  = 16;
  localparam int REF  = 4;
  localparam int AW0  = 12;
  localparam int AW1  = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [AW0-1:0]  threshold = '0;
  logic [AW0-1:0]  sad_out;
  logic            sad_valid;
  logic            spike;

  logic [7:0]      d1_in_data = '0;
  logic            d1_in_valid = 1'b0;
  logic            d1_in_ready;
  logic [AW1-1:0]  d1_threshold = '0;
  logic [AW1-1:0]  d1_sad_out;
  logic            d1_sad_valid;
  logic            d1_spike;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] win [WIN];

  always #5 clk = ~clk;

  neuron_sad_integrator #(.WINDOW(WIN), .ACC_W(AW0), .REFRACT(REF)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .threshold(threshold), .sad_out(sad_out),
    .sad_valid(sad_valid), .spike(spike)
  );

  neuron_sad_integrator #(.WINDOW(WIN), .ACC_W(AW1), .REFRACT(REF)) dut_w10 (
    .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .threshold(d1_threshold), .sad_out(d1_sad_out),
    .sad_valid(d1_sad_valid), .spike(d1_spike)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Drive win[] through the default instance and check the reported window.
  task automatic run_window(input logic [AW0-1:0] thr, input bit bp, input string tag);
    int taken = 0;
    int cyc = 0;
    int early = 0;
    int low;
    int sum = 0;
    int exp_total;
    bit exp_spk;
    bit second_pulse;
    for (int i = 0; i < WIN; i++) sum += win[i];
    exp_total = (sum > (1 << AW0) - 1) ? (1 << AW0) - 1 : sum;
    exp_spk   = (exp_total >= thr);
    threshold = thr;
    while (taken < WIN && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (sad_valid) early++;
      in_valid = bp ? 1'($urandom % 2) : 1'b1;
      in_data  = win[taken];
      if (in_valid && in_ready) taken++;
    end
    check({tag, "_timeout"}, taken, WIN);
    check({tag, "_no_early_valid"}, early, 0);
    @(negedge clk);
    in_valid = bp ? 1'($urandom % 2) : 1'b0;
    check({tag, "_sad_valid"}, sad_valid, 1);
    check({tag, "_sad_out"}, sad_out, exp_total);
    check({tag, "_spike"}, spike, exp_spk);
    low = 1;
    second_pulse = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 0) second_pulse = sad_valid | spike;
      if (in_ready) break;
      low++;
      in_valid = bp ? 1'($urandom % 2) : 1'b0;
    end
    in_valid = 1'b0;
    check({tag, "_single_pulse"}, second_pulse, 0);
    check({tag, "_ready_low_cycles"}, low, exp_spk ? 1 + REF : 1);
    check({tag, "_sad_out_held"}, sad_out, exp_total);
  endtask

  initial begin
    int n;
    int s;
    logic [AW0-1:0] thr;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_sad_out", sad_out, 0);
    check("rst_sad_valid", sad_valid, 0);
    check("rst_spike", spike, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < WIN; i++) win[i] = 8'd10;
    run_window(12'd100, 1'b0, "t10_spike");
    run_window(12'd200, 1'b0, "t10_nospike");
    for (int i = 0; i < WIN; i++) win[i] = 8'd25;
    run_window(12'd400, 1'b0, "eq_thr");
    for (int i = 0; i < WIN; i++) win[i] = 8'd3;
    run_window(12'd48, 1'b1, "backpressure");

    // Saturating instance: 16 x 255 must clamp at 1023.
    d1_threshold = 10'd1000;
    d1_in_data = 8'd255;
    n = 0;
    for (int k = 0; k < 200 && n < WIN; k++) begin
      @(negedge clk);
      d1_in_valid = 1'b1;
      if (d1_in_ready) n++;
    end
    @(negedge clk);
    d1_in_valid = 1'b0;
    check("sat_transfers", n, WIN);
    check("sat_sad_valid", d1_sad_valid, 1);
    check("sat_sad_out", d1_sad_out, 1023);
    check("sat_spike", d1_spike, 1);

    // Reset mid-window discards the partial sum.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      in_data = 8'd50;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    check("midrst_sad_out", sad_out, 0);
    check("midrst_sad_valid", sad_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < WIN; i++) win[i] = 8'd1;
    run_window(12'd100, 1'b0, "after_rst");

    for (int r = 0; r < 6; r++) begin
      s = 0;
      for (int i = 0; i < WIN; i++) begin
        win[i] = 8'($urandom);
        s += win[i];
      end
      case ($urandom % 4)
        0: thr = '0;
        1: thr = AW0'(s);
        2: thr = AW0'(s + 1);
        default: thr = AW0'($urandom);
      endcase
      run_window(thr, 1'($urandom % 2), $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
